// File: rtl/conv_encoder_framed_pkg.sv
//------------------------------------------------------------------------------
// Module  : conv_pkg
// Purpose : Shared types and constants for the K=3 rate-1/2 encoder/decoder.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } enc_state_t;

    // Trellis state {u(n-1), u(n-2)}; encodings shared with the Viterbi decoder.
    typedef logic [1:0] trellis_t;

    localparam trellis_t S0 = 2'b00;
    localparam trellis_t S1 = 2'b01;
    localparam trellis_t S2 = 2'b10;
    localparam trellis_t S3 = 2'b11;

    localparam int K        = 3;
    localparam int TAIL_LEN = K - 1;

    localparam logic [2:0] G0_DEF = 3'b111;
    localparam logic [2:0] G1_DEF = 3'b101;

endpackage

`default_nettype wire

// File: rtl/conv_encoder_framed_if.sv
//------------------------------------------------------------------------------
// Module  : conv_encoder_framed_if
// Purpose : Bit-in / symbol-out handshake bundle of the framed encoder.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface conv_encoder_framed_if #(
    parameter int LEN_W = 8
);
    logic             i_start;
    logic [LEN_W-1:0] i_frame_len;
    logic             i_valid;
    logic             i_bit;
    logic             o_ready;
    logic [1:0]       o_symbol;
    logic             o_sym_valid;
    logic             i_sym_ready;
    logic             o_sym_last;
    logic             o_busy;
    logic             o_err;

    modport master (
        output i_start, i_frame_len, i_valid, i_bit, i_sym_ready,
        input  o_ready, o_symbol, o_sym_valid, o_sym_last, o_busy, o_err
    );

    modport slave (
        input  i_start, i_frame_len, i_valid, i_bit, i_sym_ready,
        output o_ready, o_symbol, o_sym_valid, o_sym_last, o_busy, o_err
    );
endinterface

`default_nettype wire

// File: rtl/conv_branch_core.sv
//------------------------------------------------------------------------------
// Module  : conv_branch_core
// Purpose : One trellis branch: coded symbol and next state for (s, u).
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module conv_branch_core
    import conv_pkg::*;
#(
    parameter logic [2:0] G0 = G0_DEF,
    parameter logic [2:0] G1 = G1_DEF
) (
    input  trellis_t   i_s,
    input  logic       i_u,
    output logic [1:0] o_symbol,
    output trellis_t   o_ns
);
    logic [2:0] w_reg;

    assign w_reg    = {i_u, i_s};
    assign o_symbol = {^(G0 & w_reg), ^(G1 & w_reg)};
    assign o_ns     = {i_u, i_s[1]};
endmodule

`default_nettype wire

// File: rtl/conv_encoder_framed.sv
//------------------------------------------------------------------------------
// Module  : conv_encoder_framed
// Purpose : Framed K=3 rate-1/2 convolutional encoder with zero-tail flush.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module conv_encoder_framed
    import conv_pkg::*;
#(
    parameter int         LEN_W = 8,
    parameter logic [2:0] G0    = G0_DEF,
    parameter logic [2:0] G1    = G1_DEF
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst_n,
    conv_encoder_framed_if.slave  bus
);
    localparam logic [LEN_W-1:0] c_TAIL_LAST = LEN_W'(TAIL_LEN - 1);
    localparam logic [LEN_W-1:0] c_ONE       = LEN_W'(1);

    enc_state_t       r_state;
    trellis_t         r_s;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_len;
    logic [1:0]       r_sym;
    logic             r_sym_valid;
    logic             r_sym_last;
    logic             r_err;

    logic             w_free;
    logic             w_u;
    logic             w_accept;
    logic             w_tail_load;
    logic             w_load;
    logic             w_tail_last;
    logic [1:0]       w_sym;
    trellis_t         w_ns;

    assign w_free      = !r_sym_valid || bus.i_sym_ready;
    // Tail cycles feed zeros so the trellis drains back to S0.
    assign w_u         = (r_state == DATA) ? bus.i_bit : 1'b0;
    assign w_accept    = (r_state == DATA) && bus.i_valid && w_free;
    assign w_tail_load = (r_state == TAIL) && w_free;
    assign w_load      = w_accept || w_tail_load;
    assign w_tail_last = w_tail_load && (r_cnt == c_TAIL_LAST);

    conv_branch_core #(
        .G0 (G0),
        .G1 (G1)
    ) u_branch (
        .i_s      (r_s),
        .i_u      (w_u),
        .o_symbol (w_sym),
        .o_ns     (w_ns)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_s         <= S0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_sym       <= 2'b00;
            r_sym_valid <= 1'b0;
            r_sym_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= bus.i_start && ((r_state != IDLE) || (bus.i_frame_len == '0));

            // Output register only changes when it is free; otherwise it holds.
            if (w_free) begin
                r_sym_valid <= w_load;
                r_sym_last  <= w_tail_last;
                if (w_load) begin
                    r_sym <= w_sym;
                end
            end

            case (r_state)
                IDLE: begin
                    if (bus.i_start && (bus.i_frame_len != '0)) begin
                        r_len   <= bus.i_frame_len;
                        r_s     <= S0;
                        r_cnt   <= '0;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_accept) begin
                        r_s <= w_ns;
                        if (r_cnt == (r_len - c_ONE)) begin
                            r_cnt   <= '0;
                            r_state <= TAIL;
                        end else begin
                            r_cnt <= r_cnt + c_ONE;
                        end
                    end
                end
                TAIL: begin
                    if (w_tail_load) begin
                        r_s <= w_ns;
                        if (w_tail_last) begin
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + c_ONE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.o_ready     = (r_state == DATA) && w_free;
    assign bus.o_busy      = (r_state != IDLE);
    assign bus.o_symbol    = r_sym;
    assign bus.o_sym_valid = r_sym_valid;
    assign bus.o_sym_last  = r_sym_last;
    assign bus.o_err       = r_err;
endmodule

`default_nettype wire

// File: tb/tb_conv_encoder_framed.sv
//------------------------------------------------------------------------------
// Module  : tb_conv_encoder_framed
// Purpose : Directed + random frames against a convolution reference model.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_conv_encoder_framed;
    import conv_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv_encoder_framed_if #(.LEN_W(8)) bus();

    conv_encoder_framed #(
        .LEN_W (8),
        .G0    (G0_DEF),
        .G1    (G1_DEF)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] cap_sym[$];
    logic       cap_last[$];
    bit         frame[$];
    logic [1:0] exp_sym[$];

    // Symbols are recorded where the handshake will complete at the next edge.
    always @(negedge clk) begin
        if (rst_n && bus.o_sym_valid && bus.i_sym_ready) begin
            cap_sym.push_back(bus.o_symbol);
            cap_last.push_back(bus.o_sym_last);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_caps();
        cap_sym.delete();
        cap_last.delete();
    endtask

    task automatic start_frame(input int len);
        bus.i_start     = 1'b1;
        bus.i_frame_len = 8'(len);
        step();
        bus.i_start     = 1'b0;
    endtask

    task automatic send_bit(input bit b);
        int t;
        t           = 0;
        bus.i_valid = 1'b1;
        bus.i_bit   = b;
        @(negedge clk);
        while (!bus.o_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("bit_accept_timeout", 32'(t < 500), 32'd1);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic send_frame();
        start_frame(frame.size());
        foreach (frame[i]) send_bit(frame[i]);
    endtask

    task automatic random_frame(input int len);
        frame.delete();
        for (int i = 0; i < len; i++) frame.push_back(bit'($urandom_range(0, 1)));
    endtask

    // Reference: c0 = u(n)^u(n-1)^u(n-2), c1 = u(n)^u(n-2), two zero tail bits.
    task automatic build_exp();
        bit p[$];
        bit u, a, b;
        p = frame;
        p.push_back(1'b0);
        p.push_back(1'b0);
        exp_sym.delete();
        for (int n = 0; n < p.size(); n++) begin
            u = p[n];
            a = (n >= 1) ? p[n-1] : 1'b0;
            b = (n >= 2) ? p[n-2] : 1'b0;
            exp_sym.push_back({u ^ a ^ b, u ^ b});
        end
    endtask

    task automatic wait_syms(input int n);
        int t;
        t = 0;
        while (cap_sym.size() < n && t < 2000) begin
            step();
            t++;
        end
        chk("sym_count_timeout", 32'(t < 2000), 32'd1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (bus.o_busy && t < 1000) begin
            step();
            t++;
        end
        chk("idle_timeout", 32'(t < 1000), 32'd1);
    endtask

    task automatic check_frame(input string tag);
        logic [1:0] obs;
        logic       obs_last;
        bit         r1, r2, rn;
        int         bad;
        build_exp();
        wait_syms(exp_sym.size());
        wait_idle();
        step();
        chk({tag, "_count"}, cap_sym.size(), exp_sym.size());
        for (int i = 0; i < exp_sym.size(); i++) begin
            obs      = (i < cap_sym.size()) ? cap_sym[i]  : 2'bxx;
            obs_last = (i < cap_sym.size()) ? cap_last[i] : 1'bx;
            chk($sformatf("%s_sym%0d", tag, i), obs, exp_sym[i]);
            chk($sformatf("%s_last%0d", tag, i), obs_last, 32'(i == exp_sym.size() - 1));
        end
        // Loopback decode: u(n) = c1(n) ^ u(n-2).
        r1  = 1'b0;
        r2  = 1'b0;
        bad = 0;
        for (int n = 0; n < cap_sym.size(); n++) begin
            rn = cap_sym[n][0] ^ r2;
            if (n < frame.size()) begin
                if (rn != frame[n]) bad++;
            end else if (rn != 1'b0) begin
                bad++;
            end
            r2 = r1;
            r1 = rn;
        end
        chk({tag, "_loopback_errs"}, bad, 0);
    endtask

    initial begin
        logic [1:0] lit_a[6];
        logic [1:0] lit_bb[7];
        lit_a  = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        lit_bb = '{2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};

        bus.i_start     = 1'b0;
        bus.i_frame_len = '0;
        bus.i_valid     = 1'b0;
        bus.i_bit       = 1'b0;
        bus.i_sym_ready = 1'b1;
        repeat (3) step();

        chk("rst_symbol", bus.o_symbol, 2'b00);
        chk("rst_sym_valid", bus.o_sym_valid, 1'b0);
        chk("rst_sym_last", bus.o_sym_last, 1'b0);
        chk("rst_ready", bus.o_ready, 1'b0);
        chk("rst_busy", bus.o_busy, 1'b0);
        chk("rst_err", bus.o_err, 1'b0);
        rst_n = 1'b1;
        step();

        // Frame 1011, no backpressure
        clear_caps();
        frame = '{1'b1, 1'b0, 1'b1, 1'b1};
        send_frame();
        check_frame("f1011");
        for (int i = 0; i < 6; i++) chk($sformatf("f1011_lit%0d", i), cap_sym[i], lit_a[i]);
        chk("f1011_busy_after", bus.o_busy, 1'b0);

        // Same frame with a three-cycle stall on symbol 2
        clear_caps();
        fork
            send_frame();
            begin
                int t;
                t = 0;
                while (cap_sym.size() < 1 && t < 100) begin
                    step();
                    t++;
                end
                bus.i_sym_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    #1;
                    chk("stall_symbol", bus.o_symbol, 2'b10);
                    chk("stall_valid", bus.o_sym_valid, 1'b1);
                    chk("stall_ready", bus.o_ready, 1'b0);
                    step();
                end
                bus.i_sym_ready = 1'b1;
            end
        join
        check_frame("stall");

        // len=1 then back-to-back len=2 of zeros
        clear_caps();
        frame = '{1'b1};
        send_frame();
        wait_idle();
        frame = '{1'b0, 1'b0};
        send_frame();
        wait_syms(7);
        wait_idle();
        step();
        chk("b2b_count", cap_sym.size(), 7);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("b2b_sym%0d", i), cap_sym[i], lit_bb[i]);
            chk($sformatf("b2b_last%0d", i), cap_last[i], 32'(i == 2 || i == 6));
        end

        // Zero-length start rejected
        bus.i_start     = 1'b1;
        bus.i_frame_len = '0;
        step();
        bus.i_start = 1'b0;
        chk("len0_err", bus.o_err, 1'b1);
        chk("len0_busy", bus.o_busy, 1'b0);
        step();
        chk("len0_err_clears", bus.o_err, 1'b0);

        // Start while busy: rejected, frame continues undisturbed
        clear_caps();
        random_frame(4);
        start_frame(4);
        send_bit(frame[0]);
        send_bit(frame[1]);
        bus.i_start     = 1'b1;
        bus.i_frame_len = 8'd7;
        step();
        bus.i_start = 1'b0;
        chk("busy_start_err", bus.o_err, 1'b1);
        chk("busy_start_busy", bus.o_busy, 1'b1);
        send_bit(frame[2]);
        send_bit(frame[3]);
        check_frame("midstart");

        // Reset after two accepted bits
        clear_caps();
        random_frame(8);
        start_frame(8);
        send_bit(frame[0]);
        send_bit(frame[1]);
        rst_n = 1'b0;
        #1;
        chk("mrst_symbol", bus.o_symbol, 2'b00);
        chk("mrst_sym_valid", bus.o_sym_valid, 1'b0);
        chk("mrst_sym_last", bus.o_sym_last, 1'b0);
        chk("mrst_ready", bus.o_ready, 1'b0);
        chk("mrst_busy", bus.o_busy, 1'b0);
        chk("mrst_err", bus.o_err, 1'b0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("mrst_no_tail", bus.o_sym_valid, 1'b0);
        clear_caps();
        random_frame(3);
        send_frame();
        check_frame("post_rst");

        // Maximum length frame, random bits
        clear_caps();
        random_frame(255);
        send_frame();
        check_frame("max");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end
endmodule

`default_nettype wire
